// File: rtl/axi_read_arbiter_n_if.sv
// AXI4 read address / read data channel bundle shared by the arbiter and its slave.
interface axi_read_arbiter_n_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter_n.sv
// N-channel AXI4 read arbiter: grants one requester, issues one INCR burst,
// collects the beats into a line buffer and hands the whole line back.
module axi_read_arbiter_n #(
  parameter int NUM_CH    = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4,
  parameter int RR_MODE   = 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
  input  logic [NUM_CH*8-1:0]         ch_len,
  output logic [NUM_CH-1:0]           ch_grant,
  output logic [NUM_CH-1:0]           ch_rvalid,
  output logic                        ch_rerr,
  output logic [MAX_BEATS*DATA_W-1:0] ch_rdata,
  axi_read_arbiter_n_if.master        m_axi
);
  localparam int         IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         CNT_W   = $clog2(MAX_BEATS) + 1;
  localparam logic [7:0] LEN_MAX = 8'(MAX_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_ptr, r_win, w_sel, w_win_next;
  logic [IDX_W:0]     w_cand;
  logic               w_found, w_any, w_hs_ar, w_beat, w_err_next, w_start;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_len, w_len_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err, r_arvalid, r_rready, r_rerr;
  logic               w_arvalid_next, w_rready_next;
  logic [NUM_CH-1:0]  r_grant, r_rvalid, w_grant_next, w_rvalid_next;
  logic [7:0]         w_len_arr  [NUM_CH];
  logic [ADDR_W-1:0]  w_addr_arr [NUM_CH];
  logic               w_unused_rid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_len_arr[gi]  = ch_len[gi*8 +: 8];
      assign w_addr_arr[gi] = ch_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Cyclic search from r_ptr (round-robin) or from index 0 (fixed priority).
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (RR_MODE != 0) begin
        w_cand = (IDX_W+1)'(r_ptr) + (IDX_W+1)'(i);
        if (w_cand >= (IDX_W+1)'(NUM_CH)) w_cand = w_cand - (IDX_W+1)'(NUM_CH);
      end else begin
        w_cand = (IDX_W+1)'(i);
      end
      if (!w_found && ch_req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_any      = |ch_req;
  assign w_start    = (r_state == S_IDLE) && w_any;
  assign w_len_sel  = (w_len_arr[w_sel] > LEN_MAX) ? LEN_MAX : w_len_arr[w_sel];
  assign w_hs_ar    = r_arvalid && m_axi.arready;
  assign w_beat     = r_rready && m_axi.rvalid;
  assign w_err_next = r_err || (w_beat && (m_axi.rresp != 2'b00));
  assign w_win_next = (r_state == S_IDLE) ? w_sel : r_win;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_ADDR;
      S_ADDR:  if (w_hs_ar) w_state_next = S_DATA;
      S_DATA:  if (w_beat && m_axi.rlast) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they leave flops directly.
  always_comb begin
    w_arvalid_next = (w_state_next == S_ADDR);
    w_rready_next  = (w_state_next == S_DATA);
    w_grant_next   = '0;
    w_rvalid_next  = '0;
    if (w_state_next != S_IDLE) w_grant_next[w_win_next] = 1'b1;
    if (w_state_next == S_DONE) w_rvalid_next[w_win_next] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_grant   <= '0;
      r_rvalid  <= '0;
      r_rerr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_arvalid <= w_arvalid_next;
      r_rready  <= w_rready_next;
      r_grant   <= w_grant_next;
      r_rvalid  <= w_rvalid_next;
      r_rerr    <= (w_state_next == S_DONE) && w_err_next;
      if (w_start) begin
        r_win  <= w_sel;
        r_addr <= w_addr_arr[w_sel];
        r_len  <= w_len_sel;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_beat) begin
        r_err <= w_err_next;
        if (r_cnt != CNT_W'(MAX_BEATS)) r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_DONE && RR_MODE != 0)
        r_ptr <= (r_win == IDX_W'(NUM_CH - 1)) ? '0 : r_win + 1'b1;
    end
  end

  // Line buffer; a saturated r_cnt matches no slot, so overflow beats are dropped.
  generate
    for (gi = 0; gi < MAX_BEATS; gi++) begin : g_buf
      logic [DATA_W-1:0] r_slot;
      always_ff @(posedge aclk) begin
        if (!aresetn || w_start) r_slot <= '0;
        else if (w_beat && r_cnt == CNT_W'(gi)) r_slot <= m_axi.rdata;
      end
      assign ch_rdata[gi*DATA_W +: DATA_W] = r_slot;
    end
  endgenerate

  assign w_unused_rid  = ^m_axi.rid;
  assign ch_grant      = r_grant;
  assign ch_rvalid     = r_rvalid;
  assign ch_rerr       = r_rerr;
  assign m_axi.arid    = 4'(r_win);
  assign m_axi.araddr  = r_addr;
  assign m_axi.arlen   = r_len;
  assign m_axi.arsize  = 3'($clog2(DATA_W / 8));
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;
endmodule
